// File: rtl/log_bf16_pkg.sv
// Shared constants, piecewise-linear ln(1.m) table and stage payload types for the
// bf16 natural-log pipeline.
package log_bf16_pkg;

  localparam logic [15:0] NEG_INF = 16'hff80;
  localparam logic [15:0] POS_INF = 16'h7f80;
  localparam logic [15:0] QNAN    = 16'h7fc0;

  // ln(2) in Q16
  localparam int unsigned LN2_Q16 = 45426;

  // Segment j covers mantissa m[6:4] == j; ln(1.m) ~= BASE[j] + SLOPE[j] * m[3:0] (Q16)
  localparam logic [15:0] BASE [8] = '{
    16'd0, 16'd7719, 16'd14624, 16'd20870, 16'd26573, 16'd31818, 16'd36675, 16'd41197
  };
  localparam logic [8:0] SLOPE [8] = '{
    9'd482, 9'd432, 9'd390, 9'd356, 9'd328, 9'd304, 9'd283, 9'd264
  };

  typedef struct packed {
    logic               special;
    logic [15:0]        spec_val;
    logic signed [8:0]  k;
    logic [2:0]         j;
    logic [3:0]         t;
  } s1_t;

  typedef struct packed {
    logic               special;
    logic [15:0]        spec_val;
    logic signed [25:0] sum;
  } s2_t;

endpackage

// File: rtl/lod26.sv
// Combinational 26-bit leading-one detector: position of the highest set bit and a
// zero flag when no bit is set.
module lod26 (
  input  logic [25:0] a_i,
  output logic [4:0]  pos_o,
  output logic        zero_o
);

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < 26; i++) begin
      if (a_i[i]) pos_o = 5'(i);
    end
  end

  assign zero_o = (a_i == '0);

endmodule

// File: rtl/log_bf16.sv
// Three-stage bf16 natural logarithm: classify, form k*ln2 + ln(1.m) in Q9.16, then
// normalize back to bf16 with truncation. Single global stall on output backpressure.
module log_bf16
  import log_bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_o
);

  logic        adv;
  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t         s1_q, s1_d, s1_in;
  s2_t         s2_q, s2_d, s2_in;
  logic [15:0] data_q, data_d, res;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign data_o    = data_q;

  // S1: classify operand
  always_comb begin
    s1_in          = '0;
    s1_in.k        = {1'b0, data_i[14:7]} - 9'd127;
    s1_in.j        = data_i[6:4];
    s1_in.t        = data_i[3:0];
    if (data_i[14:7] == 8'h00) begin
      s1_in.special  = 1'b1;
      s1_in.spec_val = NEG_INF;
    end else if (data_i[14:7] == 8'hff && data_i[6:0] != 7'h00) begin
      s1_in.special  = 1'b1;
      s1_in.spec_val = QNAN;
    end else if (data_i[14:7] == 8'hff && !data_i[15]) begin
      s1_in.special  = 1'b1;
      s1_in.spec_val = POS_INF;
    end else if (data_i[15]) begin
      s1_in.special  = 1'b1;
      s1_in.spec_val = QNAN;
    end
  end

  // S2: S = k*ln2 + BASE[j] + SLOPE[j]*t
  logic signed [25:0] k_ext;
  logic [12:0]        lin;

  always_comb begin
    k_ext          = {{17{s1_q.k[8]}}, s1_q.k};
    lin            = 13'(SLOPE[s1_q.j]) * 13'(s1_q.t);
    s2_in          = '0;
    s2_in.special  = s1_q.special;
    s2_in.spec_val = s1_q.spec_val;
    s2_in.sum      = k_ext * $signed(26'(LN2_Q16))
                   + $signed({10'd0, BASE[s1_q.j]})
                   + $signed({13'd0, lin});
  end

  // S3: magnitude, leading-one detect, truncating normalize
  logic [25:0] abs_val;
  logic [4:0]  lead_pos;
  logic        lead_zero;
  logic [6:0]  mant;

  assign abs_val = s2_q.sum[25] ? 26'(-s2_q.sum) : 26'(s2_q.sum);

  lod26 u_lod26 (
    .a_i    (abs_val),
    .pos_o  (lead_pos),
    .zero_o (lead_zero)
  );

  // Leading one moved to bit 25; the next seven bits are the mantissa (zero-filled if short)
  assign mant = 7'((abs_val << (5'd25 - lead_pos)) >> 18);

  always_comb begin
    if (s2_q.special) begin
      res = s2_q.spec_val;
    end else if (lead_zero) begin
      res = 16'h0000;
    end else begin
      res = {s2_q.sum[25], 8'd111 + {3'd0, lead_pos}, mant};
    end
  end

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    data_d = data_q;
    if (adv) begin
      v1_d   = in_valid;
      s1_d   = s1_in;
      v2_d   = v1_q;
      s2_d   = s2_in;
      v3_d   = v2_q;
      data_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      data_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_log_bf16.sv
// Self-checking bench for log_bf16: directed literals, scoreboard against an integer
// reference of the table/truncation rules, and a real-ln accuracy bound.
module tb_log_bf16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_o;

  log_bf16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stall_cnt = 0;
  logic [15:0] cur_exp;

  typedef struct {
    logic [15:0] x;
    logic [15:0] ex;
    int          acc_cyc;
    int          snap;
  } ent_t;
  ent_t sb[$];

  int base_t  [8] = '{0, 7719, 14624, 20870, 26573, 31818, 36675, 41197};
  int slope_t [8] = '{482, 432, 390, 356, 328, 304, 283, 264};

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
  endtask

  function automatic logic [15:0] golden(input logic [15:0] x);
    int e, m, k, s, a, p, mnt;
    logic neg;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 0) return 16'hff80;
    if (e == 255 && m != 0) return 16'h7fc0;
    if (e == 255 && !x[15]) return 16'h7f80;
    if (x[15]) return 16'h7fc0;
    k = e - 127;
    s = k * 45426 + base_t[m / 16] + slope_t[m / 16] * (m % 16);
    if (s == 0) return 16'h0000;
    neg = (s < 0);
    a = neg ? -s : s;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    mnt = (p >= 7) ? ((a >> (p - 7)) & 127) : ((a << (7 - p)) & 127);
    return {neg, 8'(111 + p), 7'(mnt)};
  endfunction

  function automatic real bf16_to_real(input logic [15:0] v);
    real r;
    if (v[14:7] == 8'd0) return 0.0;
    r = (1.0 + real'(v[6:0]) / 128.0) * $pow(2.0, real'(int'(v[14:7])) - 127.0);
    return v[15] ? -r : r;
  endfunction

  task automatic check_accuracy(input logic [15:0] x, input logic [15:0] got);
    real truth, err, tol;
    truth = $ln(bf16_to_real(x));
    err   = bf16_to_real(got) - truth;
    if (err < 0.0) err = -err;
    tol = 1.0 / 256.0;
    if (got[14:7] != 8'd0) tol = tol + 2.0 * $pow(2.0, real'(int'(got[14:7])) - 134.0);
    n_checks++;
    if (err <= tol) n_pass++;
    else $display("FAIL accuracy x=%h got=%h err=%f tol=%f", x, got, err, tol);
  endtask

  // Monitor: handshakes sampled on the falling edge, i.e. what the next rising edge will do
  always @(negedge clk) begin
    ent_t en;
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back('{data_i, cur_exp, cyc, stall_cnt});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_result", int'(data_o), -1);
        end else begin
          en = sb.pop_front();
          check("result", int'(data_o), int'(en.ex));
          check("latency", cyc - en.acc_cyc, 3 + stall_cnt - en.snap);
          if (!en.x[15] && en.x[14:7] >= 8'd100 && en.x[14:7] <= 8'd160)
            check_accuracy(en.x, data_o);
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic drive(input logic [15:0] x, input logic [15:0] ex);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    data_i   = x;
    cur_exp  = ex;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  logic [15:0] dir_x  [5] = '{16'h3f80, 16'h4000, 16'h3f00, 16'h4080, 16'h3fc0};
  logic [15:0] dir_e  [5] = '{16'h0000, 16'h3f31, 16'hbf31, 16'h3fb1, 16'h3ecf};
  logic [15:0] spc_x  [6] = '{16'h0000, 16'h8000, 16'h0001, 16'h7f80, 16'h7fc1, 16'hbf80};
  logic [15:0] spc_e  [6] = '{16'hff80, 16'hff80, 16'hff80, 16'h7f80, 16'h7fc0, 16'h7fc0};
  logic [15:0] bp_x   [6] = '{16'h3f80, 16'h4000, 16'h4040, 16'h3e80, 16'h4300, 16'h3a00};
  logic        vh     [12];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_i    = 16'h0;
    cur_exp   = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_data_o", int'(data_o), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", int'(in_ready), 1);

    // Directed exact values then specials, back-to-back
    for (int i = 0; i < 5; i++) drive(dir_x[i], dir_e[i]);
    for (int i = 0; i < 6; i++) drive(spc_x[i], spc_e[i]);
    drain();

    // Backpressure: 4-cycle stall once the first result shows
    fork
      begin
        for (int i = 0; i < 6; i++) drive(bp_x[i], golden(bp_x[i]));
      end
      begin
        int          n = 0;
        logic [15:0] held;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        check("bp_out_valid_seen", int'(out_valid), 1);
        out_ready = 1'b0;
        #1;
        held = data_o;
        repeat (4) begin
          check("bp_in_ready_low", int'(in_ready), 0);
          check("bp_data_stable", int'(data_o), int'(held));
          check("bp_out_valid_held", int'(out_valid), 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: out_valid mirrors the input valid pattern three cycles later
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8) && (i % 2 == 0);
      data_i   = 16'h4000 + 16'(i * 5);
      cur_exp  = golden(data_i);
      @(negedge clk);
      vh[i] = in_valid && in_ready;
      if (i >= 3) check("bubble_out_valid", int'(out_valid), int'(vh[i-3]));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset with three operands in flight (one already visible at the output)
    drive(16'h4000, golden(16'h4000));
    drive(16'h4080, golden(16'h4080));
    drive(16'h3f00, golden(16'h3f00));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_data_o", int'(data_o), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    @(posedge clk);
    #2;
    check("midrst_hold_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    #1;
    check("midrst_release_in_ready", int'(in_ready), 1);
    check("midrst_release_out_valid", int'(out_valid), 0);
    drive(16'h3fc0, 16'h3ecf);
    drain();

    // Sweep every positive normal operand
    for (int e = 1; e < 255; e++) begin
      for (int m = 0; m < 128; m++) begin
        logic [15:0] x;
        x = {1'b0, 8'(e), 7'(m)};
        drive(x, golden(x));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
